// File: rtl/upsample_layer_pkg.sv
// Shared layer-chain definitions: FSM state encoding and default pixel width.
package upsample_layer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } layer_state_t;

   localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/upsample_layer_if.sv
// Pixel stream bundle for the upsample layer: input stream plus output stream
// with row/frame markers. slave is the layer's view, master the environment's.
interface upsample_layer_if
   import upsample_layer_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_row_end;
   logic                     out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_row_end, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_row_end, out_last
   );
endinterface

// File: rtl/upsample_row_buffer.sv
// Ping-pong pair of input rows. A row becomes full when its last pixel is
// written and is released by the reader after both replays of that row.
module upsample_row_buffer
   import upsample_layer_pkg::*;
#(
   parameter int IN_W   = 3,
   parameter int DATA_W = DEFAULT_DATA_W,
   localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic                     rd_release,
   input  logic [COL_W-1:0]         rd_idx,
   output logic                     wr_full,
   output logic                     rd_full,
   output logic                     row_written,
   output logic signed [DATA_W-1:0] rd_data
);
   logic signed [DATA_W-1:0] mem [2][IN_W];
   logic [1:0]               full;
   logic                     wr_buf;
   logic                     rd_buf;
   logic [COL_W-1:0]         wr_col;

   assign row_written = wr_en && (wr_col == COL_W'(IN_W - 1));
   assign wr_full     = full[wr_buf];
   assign rd_full     = full[rd_buf];
   assign rd_data     = mem[rd_buf][rd_idx];

   // Pixel storage; contents are only ever observed behind a full flag.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_buf][wr_col] <= wr_data;
   end

   // Fill/release bookkeeping; fill and release always hit different rows.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         full   <= 2'b00;
         wr_buf <= 1'b0;
         rd_buf <= 1'b0;
         wr_col <= '0;
      end else begin
         if (wr_en) begin
            if (row_written) begin
               full[wr_buf] <= 1'b1;
               wr_buf       <= ~wr_buf;
               wr_col       <= '0;
            end else begin
               wr_col <= wr_col + 1'b1;
            end
         end
         if (rd_release) begin
            full[rd_buf] <= 1'b0;
            rd_buf       <= ~rd_buf;
         end
      end
   end
endmodule

// File: rtl/upsample_layer.sv
// 2x nearest-neighbour upsampler: each buffered input row is replayed twice,
// with every pixel emitted twice per replay.
module upsample_layer
   import upsample_layer_pkg::*;
#(
   parameter int IN_W   = 3,
   parameter int IN_H   = 3,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   upsample_layer_if.slave  bus,
   output logic             busy,
   output logic             done
);
   localparam int COL_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int OCOL_W = $clog2(2 * IN_W);
   localparam int ROW_W  = $clog2(IN_H + 1);

   layer_state_t             state;
   logic [ROW_W-1:0]         in_row;
   logic [ROW_W-1:0]         rd_row;
   logic [OCOL_W-1:0]        out_col;
   logic                     rep;
   logic                     wr_full;
   logic                     rd_full;
   logic                     row_written;
   logic signed [DATA_W-1:0] rd_data;
   logic                     frame_start;
   logic                     in_hs;
   logic                     out_hs;
   logic                     col_end;
   logic                     row_release;

   assign frame_start = (state == IDLE) && start;
   assign in_hs       = bus.in_valid && bus.in_ready;
   assign out_hs      = bus.out_valid && bus.out_ready;
   assign col_end     = (out_col == OCOL_W'(2 * IN_W - 1));
   assign row_release = out_hs && col_end && rep;

   assign bus.in_ready    = (state == RUN) && !wr_full && (in_row < ROW_W'(IN_H));
   assign bus.out_valid   = (state == RUN) && rd_full;
   // Gated so the data lines read zero whenever nothing is being offered.
   assign bus.out_data    = bus.out_valid ? rd_data : '0;
   assign bus.out_row_end = bus.out_valid && col_end;
   assign bus.out_last    = bus.out_row_end && rep && (rd_row == ROW_W'(IN_H - 1));
   assign busy            = (state == RUN);
   assign done            = (state == DONE);

   upsample_row_buffer #(
      .IN_W   (IN_W),
      .DATA_W (DATA_W)
   ) u_row_buffer (
      .clk         (clk),
      .rst         (rst),
      .clear       (frame_start),
      .wr_en       (in_hs),
      .wr_data     (bus.in_data),
      .rd_release  (row_release),
      .rd_idx      (COL_W'(out_col >> 1)),
      .wr_full     (wr_full),
      .rd_full     (rd_full),
      .row_written (row_written),
      .rd_data     (rd_data)
   );

   // Frame sequencing plus input-row and output col/rep/row counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         in_row  <= '0;
         rd_row  <= '0;
         out_col <= '0;
         rep     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  in_row  <= '0;
                  rd_row  <= '0;
                  out_col <= '0;
                  rep     <= 1'b0;
               end
            end
            RUN: begin
               if (row_written) in_row <= in_row + 1'b1;
               if (out_hs) begin
                  if (bus.out_last) state <= DONE;
                  if (col_end) begin
                     out_col <= '0;
                     if (!rep) begin
                        rep <= 1'b1;
                     end else begin
                        rep    <= 1'b0;
                        rd_row <= rd_row + 1'b1;
                     end
                  end else begin
                     out_col <= out_col + 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
